// File: rtl/osd_input_pkg.sv
// Shared types and constants for the OSD input sequencer.
// Optional coin counter is enabled with the OSD_COIN_COUNTER_EN macro.
package osd_input_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam int CH_COIN   = 0;
    localparam int CH_START1 = 1;
    localparam int CH_START2 = 2;
    localparam int CH_RESET  = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/osd_input_sequencer_if.sv
// Bus between the OSD/joystick sources and the game core inputs.
// Handshake: none; all signals are levels sampled on the rising clock edge.
interface osd_input_sequencer_if;
    import osd_input_pkg::*;

    logic [3:0] status_trig;
    logic       joy_coin;
    logic       joy_start1;
    logic       joy_start2;
    logic       coin_o;
    logic       start1_o;
    logic       start2_o;
    logic       soft_rst_n_o;
    logic       busy;
    state_t     dbg_state;
`ifdef OSD_COIN_COUNTER_EN
    logic [7:0] coin_count;

    modport master (
        output status_trig, joy_coin, joy_start1, joy_start2,
        input  coin_o, start1_o, start2_o, soft_rst_n_o, busy, dbg_state, coin_count
    );
    modport slave (
        input  status_trig, joy_coin, joy_start1, joy_start2,
        output coin_o, start1_o, start2_o, soft_rst_n_o, busy, dbg_state, coin_count
    );
`else
    modport master (
        output status_trig, joy_coin, joy_start1, joy_start2,
        input  coin_o, start1_o, start2_o, soft_rst_n_o, busy, dbg_state
    );
    modport slave (
        input  status_trig, joy_coin, joy_start1, joy_start2,
        output coin_o, start1_o, start2_o, soft_rst_n_o, busy, dbg_state
    );
`endif

endinterface

// File: rtl/osd_down_counter.sv
// Loadable down counter that stops at zero; load has priority over decrement.
module osd_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/osd_input_sequencer.sv
// Turns OSD trigger toggles into timed, serialized coin/start presses and a soft reset.
// Define OSD_COIN_COUNTER_EN to add the saturating coin_count output.
module osd_input_sequencer
    import osd_input_pkg::*;
#(
    parameter int PULSE_CYCLES = 600000,
    parameter int GAP_CYCLES   = 300000,
    parameter int RESET_CYCLES = 65536
) (
    input logic                  clk,
    input logic                  rst_n,
    osd_input_sequencer_if.slave bus
);

    localparam int CNT_W = $clog2(max3(PULSE_CYCLES, GAP_CYCLES, RESET_CYCLES) + 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LD = CNT_W'(RESET_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d, pick;
    logic [2:0]       pend_q, pend_d, clr_mask, hold_mask;
    logic [3:0]       trig_q, trig_d, rise;
    logic [2:0]       joy_q, joy_d;
    logic [2:0]       out_q, out_d;
    logic             srn_q, srn_d;
    logic             in_rst;
    logic             hold_load, hold_dec, hold_zero;
    logic [CNT_W-1:0] hold_val;
    logic             rst_zero;

    assign rise      = bus.status_trig & ~trig_q;
    // Soft reset is active on the triggering edge and for every cycle its output is low.
    assign in_rst    = rise[CH_RESET] | ~srn_q;
    assign hold_mask = (state_q == ST_HOLD) ? (3'b001 << sel_q) : 3'b000;

    always_comb begin
        pick = 2'(CH_START2);
        if (pend_q[CH_COIN])        pick = 2'(CH_COIN);
        else if (pend_q[CH_START1]) pick = 2'(CH_START1);
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        clr_mask  = 3'b000;
        hold_load = 1'b0;
        hold_dec  = 1'b0;
        hold_val  = '0;
        if (in_rst) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pend_q != 3'b000) begin
                        state_d   = ST_HOLD;
                        sel_d     = pick;
                        clr_mask  = 3'b001 << pick;
                        hold_load = 1'b1;
                        hold_val  = PULSE_LD;
                    end
                end
                ST_HOLD: begin
                    if (hold_zero) begin
                        state_d   = ST_GAP;
                        hold_load = 1'b1;
                        hold_val  = GAP_LD;
                    end else begin
                        hold_dec = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (hold_zero) state_d = ST_IDLE;
                    else           hold_dec = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A rise on the channel being held merges into that press; a rise in the gap re-queues.
    always_comb begin
        trig_d = bus.status_trig;
        joy_d  = {bus.joy_start2, bus.joy_start1, bus.joy_coin};
        pend_d = in_rst ? 3'b000 : ((pend_q & ~clr_mask) | (rise[2:0] & ~hold_mask));
        out_d  = (rise[CH_RESET] ? 3'b000 : hold_mask) | joy_q;
        srn_d  = ~rise[CH_RESET] & rst_zero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= 2'b00;
            pend_q  <= 3'b000;
            trig_q  <= 4'b0000;
            joy_q   <= 3'b000;
            out_q   <= 3'b000;
            srn_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            trig_q  <= trig_d;
            joy_q   <= joy_d;
            out_q   <= out_d;
            srn_q   <= srn_d;
        end
    end

    osd_down_counter #(.WIDTH(CNT_W)) u_hold_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (hold_load),
        .load_val (hold_val),
        .dec      (hold_dec),
        .zero     (hold_zero)
    );

    osd_down_counter #(.WIDTH(CNT_W)) u_rst_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (rise[CH_RESET]),
        .load_val (RESET_LD),
        .dec      (1'b1),
        .zero     (rst_zero)
    );

`ifdef OSD_COIN_COUNTER_EN
    logic [7:0] coin_count_q, coin_count_d;
    logic [1:0] coin_inc;

    always_comb begin
        coin_inc = 2'(((state_q == ST_IDLE) && (state_d == ST_HOLD) && (sel_d == 2'(CH_COIN))) ? 1 : 0)
                 + 2'((bus.joy_coin & ~joy_q[CH_COIN]) ? 1 : 0);
        if ((9'(coin_count_q) + 9'(coin_inc)) > 9'd255) coin_count_d = 8'd255;
        else                                             coin_count_d = coin_count_q + 8'(coin_inc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) coin_count_q <= 8'd0;
        else        coin_count_q <= coin_count_d;
    end

    assign bus.coin_count = coin_count_q;
`endif

    assign bus.coin_o       = out_q[CH_COIN];
    assign bus.start1_o     = out_q[CH_START1];
    assign bus.start2_o     = out_q[CH_START2];
    assign bus.soft_rst_n_o = srn_q;
    assign bus.busy         = (state_q != ST_IDLE) | (pend_q != 3'b000) | ~srn_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_osd_input_sequencer.sv
// Self-checking bench for osd_input_sequencer: directed table, corner sequences, random vs model.
module tb_osd_input_sequencer;
  import osd_input_pkg::*;

  localparam int P = 4;
  localparam int G = 2;
  localparam int R = 8;

  typedef struct {
    logic [3:0] trig;
    logic [2:0] joy;
    logic [4:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  osd_input_sequencer_if bus_if();

  osd_input_sequencer #(
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G),
    .RESET_CYCLES (R)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] exp_q[$];

  // ---------------- reference model (timestamp based) ----------------
  int         m_t;
  int         m_ch;
  int         m_tsel;
  int         m_rst_last;
  bit         m_active;
  logic [3:0] m_trig_prev;
  logic [2:0] m_pend;
  logic [2:0] m_joy_prev;

  task automatic model_reset();
    m_t         = 0;
    m_ch        = 0;
    m_tsel      = 0;
    m_rst_last  = -100;
    m_active    = 0;
    m_trig_prev = 4'b0000;
    m_pend      = 3'b000;
    m_joy_prev  = 3'b000;
    exp_q.delete();
  endtask

  // 0 = idle, 1 = press held, 2 = forced gap; as seen just after edge t
  function automatic int phase_after(input int t);
    int k;
    if (!m_active) return 0;
    k = t - m_tsel;
    if (k < P) return 1;
    if (k < P + G) return 2;
    return 0;
  endfunction

  task automatic model_step(input logic [3:0] trig, input logic [2:0] joy);
    logic [3:0] rise;
    logic [2:0] hold_mask, seq, np, out;
    int ph;
    bit in_rst, srn, busy;
    m_t++;
    rise = trig & ~m_trig_prev;
    m_trig_prev = trig;
    ph = phase_after(m_t - 1);
    if (ph == 0) m_active = 0;
    in_rst = rise[3] || (m_t - 1 <= m_rst_last);
    hold_mask = (ph == 1) ? (3'b001 << m_ch) : 3'b000;
    seq = rise[3] ? 3'b000 : hold_mask;
    if (in_rst) begin
      m_pend = 3'b000;
      m_active = 0;
    end else begin
      np = m_pend;
      if (ph == 0 && m_pend != 3'b000) begin
        for (int c = 2; c >= 0; c--) if (m_pend[c]) m_ch = c;
        np[m_ch] = 1'b0;
        m_active = 1;
        m_tsel = m_t;
      end
      m_pend = np | (rise[2:0] & ~hold_mask);
    end
    if (rise[3]) m_rst_last = m_t + R - 1;
    srn = !(m_t <= m_rst_last);
    out = seq | m_joy_prev;
    m_joy_prev = joy;
    busy = (phase_after(m_t) != 0) || (m_pend != 3'b000) || !srn;
    exp_q.push_back({out[0], out[1], out[2], srn, busy});
  endtask

  // ---------------- driver / checker ----------------
  function automatic logic [4:0] observe();
    return {bus_if.coin_o, bus_if.start1_o, bus_if.start2_o, bus_if.soft_rst_n_o, bus_if.busy};
  endfunction

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (coin,start1,start2,soft_rst_n,busy)", name, got, want);
    end
  endtask

  task automatic apply(input logic [3:0] trig, input logic [2:0] joy);
    @(negedge clk);
    bus_if.status_trig = trig;
    bus_if.joy_coin    = joy[0];
    bus_if.joy_start1  = joy[1];
    bus_if.joy_start2  = joy[2];
    @(posedge clk);
  endtask

  task automatic run(input string name, input logic [3:0] trig, input logic [2:0] joy, input int n);
    for (int i = 0; i < n; i++) begin
      apply(trig, joy);
      model_step(trig, joy);
      #1;
      check($sformatf("%s[%0d]", name, i), observe(), exp_q.pop_front());
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    bus_if.status_trig = 4'b0000;
    bus_if.joy_coin = 1'b0;
    bus_if.joy_start1 = 1'b0;
    bus_if.joy_start2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    model_step(4'b0000, 3'b000);
    #1;
    check(name, observe(), exp_q.pop_front());
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t tbl[23];
    logic [3:0] r_trig;
    logic [2:0] r_joy;

    tbl[0]  = '{4'b0000, 3'b000, 5'b00010};
    tbl[1]  = '{4'b0001, 3'b000, 5'b00011};
    tbl[2]  = '{4'b0000, 3'b000, 5'b00011};
    tbl[3]  = '{4'b0000, 3'b000, 5'b10011};
    tbl[4]  = '{4'b0000, 3'b000, 5'b10011};
    tbl[5]  = '{4'b0000, 3'b000, 5'b10011};
    tbl[6]  = '{4'b0000, 3'b000, 5'b10011};
    tbl[7]  = '{4'b0000, 3'b000, 5'b00011};
    tbl[8]  = '{4'b0000, 3'b000, 5'b00010};
    tbl[9]  = '{4'b0000, 3'b000, 5'b00010};
    tbl[10] = '{4'b0000, 3'b100, 5'b00010};
    tbl[11] = '{4'b0000, 3'b000, 5'b00110};
    tbl[12] = '{4'b0000, 3'b000, 5'b00010};
    for (int i = 13; i <= 20; i++) tbl[i] = '{4'b1000, 3'b000, 5'b00001};
    tbl[21] = '{4'b0000, 3'b000, 5'b00010};
    tbl[22] = '{4'b0000, 3'b000, 5'b00010};

    rst_n = 1'b0;
    bus_if.status_trig = 4'b0000;
    bus_if.joy_coin = 1'b0;
    bus_if.joy_start1 = 1'b0;
    bus_if.joy_start2 = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_values", observe(), 5'b00010);
    n_checks++;
    if (bus_if.dbg_state !== ST_IDLE) begin
      n_errors++;
      $display("FAIL reset_state: got %0d expected %0d", bus_if.dbg_state, ST_IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // directed table: single coin press, joystick latency, soft reset length
    for (int i = 0; i < 23; i++) begin
      apply(tbl[i].trig, tbl[i].joy);
      #1;
      check($sformatf("table[%0d]", i), observe(), tbl[i].exp);
    end

    do_reset("resync");

    // simultaneous coin/start1/start2
    run("t2_all", 4'b0111, 3'b000, 1);
    run("t2_seq", 4'b0000, 3'b000, 25);

    // coin re-trigger during hold (merged) and during gap (re-issued)
    run("t3_arm",  4'b0001, 3'b000, 1);
    run("t3_a",    4'b0000, 3'b000, 2);
    run("t3_hold", 4'b0001, 3'b000, 1);
    run("t3_b",    4'b0000, 3'b000, 2);
    run("t3_gap",  4'b0001, 3'b000, 1);
    run("t3_tail", 4'b0000, 3'b000, 20);

    // soft reset in the middle of a start1 press; coin rise during reset discarded
    run("t4_arm",   4'b0010, 3'b000, 1);
    run("t4_hold",  4'b0000, 3'b000, 3);
    run("t4_rst",   4'b1000, 3'b000, 1);
    run("t4_a",     4'b0000, 3'b000, 3);
    run("t4_coin",  4'b0001, 3'b000, 1);
    run("t4_tail",  4'b0000, 3'b000, 15);

    // soft reset extended by a second trigger
    run("t4x_rst",  4'b1000, 3'b000, 1);
    run("t4x_a",    4'b0000, 3'b000, 4);
    run("t4x_rst2", 4'b1000, 3'b000, 1);
    run("t4x_tail", 4'b0000, 3'b000, 12);

    // joystick start2 held during a coin sequence
    run("t5_arm",  4'b0001, 3'b000, 1);
    run("t5_joy",  4'b0000, 3'b100, 20);
    run("t5_tail", 4'b0000, 3'b000, 15);

    // global reset mid-hold
    run("t6_arm",  4'b0001, 3'b000, 1);
    run("t6_hold", 4'b0000, 3'b000, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_async", observe(), 5'b00010);
    @(posedge clk);
    #1;
    check("t6_held", observe(), 5'b00010);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    model_step(4'b0000, 3'b000);
    #1;
    check("t6_release", observe(), exp_q.pop_front());
    run("t6_after", 4'b0000, 3'b000, 12);

    // randomized stimulus against the model
    r_trig = 4'b0000;
    r_joy  = 3'b000;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        r_trig[2:0] = 3'($urandom_range(0, 7));
        r_trig[3]   = ($urandom_range(0, 9) == 0);
      end
      if ($urandom_range(0, 9) == 0) r_joy = 3'($urandom_range(0, 7));
      run("rand", r_trig, r_joy, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
